// File: rtl/fir_pipelined_tree.sv
// fir_pipelined_tree
// Fully pipelined direct-form FIR filter. The delay line shifts on in_valid,
// every tap product is registered, and the products are summed by a binary
// adder tree with one register stage per level. The accumulator is rounded
// (half up), shifted right by OUT_SHIFT and reduced to OUT_W bits.
//
// Build option: define FIR_SATURATE_EN to clamp the shifted result to the
// OUT_W signed range; without it the low OUT_W bits are taken (wrap).
// Latency is the same in both builds: STAGES+2 edges from sample capture.
//
// Handshake: in_valid qualifies in_data for the cycle it is high; there is
// no ready, every valid sample is accepted. out_valid is high for exactly
// one cycle per accepted sample that is not dropped by clear or reset, and
// out_data changes only on those cycles.
//
// OUT_W must not exceed DATA_W+COEF_W+$clog2(TAPS)+1.
module fir_pipelined_tree #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 16,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data
);

  // Derived sizes; these follow from the parameters above.
  localparam int STAGES = $clog2(TAPS);
  localparam int ACC_W  = DATA_W + COEF_W + STAGES;
  localparam int ADDR_W = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int LEAVES = 1 << STAGES;
  // Heap layout: node[0] is the root, node[i] sums node[2i+1] and node[2i+2],
  // leaves (registered products) sit at node[LEAVES-1 .. 2*LEAVES-2].
  localparam int NODES  = 2 * LEAVES - 1;

  // Half-LSB rounding constant at the output scale (zero when not shifting).
  localparam logic signed [ACC_W:0] RND =
    (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [DATA_W-1:0] tap      [TAPS];
  logic signed [COEF_W-1:0] coef     [TAPS];
  logic signed [ACC_W-1:0]  prod_ext [TAPS];
  logic signed [ACC_W-1:0]  node     [NODES];
  logic        [STAGES+1:0] vpipe;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    shifted;
  logic signed [OUT_W-1:0]  result;

  // Delay line: shifts only on accepted samples; clear flushes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) tap[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < TAPS; k++) tap[k] <= '0;
    end else if (in_valid) begin
      tap[0] <= $signed(in_data);
      for (int k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
    end
  end

  // Coefficient bank: out-of-range addresses match no tap and are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (coef_we) begin
      for (int k = 0; k < TAPS; k++) begin
        if (coef_addr == ADDR_W'(k)) coef[k] <= $signed(coef_wdata);
      end
    end
  end

  // Full-precision signed products, sign-extended to the accumulator width.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_ext[k] = ACC_W'(PROD_W'(coef[k]) * PROD_W'(tap[k]));
    end
  end

  // Product registers (tree leaves) and one register per adder-tree level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NODES; i++) node[i] <= '0;
    end else begin
      for (int i = 0; i < LEAVES - 1; i++) node[i] <= node[2*i+1] + node[2*i+2];
      for (int k = 0; k < TAPS; k++) node[LEAVES-1+k] <= prod_ext[k];
      for (int k = TAPS; k < LEAVES; k++) node[LEAVES-1+k] <= '0;
    end
  end

  // Round half up, arithmetic shift, then reduce to the output width.
  always_comb begin
    rounded = (ACC_W+1)'(node[0]) + RND;
    shifted = rounded >>> OUT_SHIFT;
`ifdef FIR_SATURATE_EN
    if (shifted > (ACC_W+1)'(OUT_MAX))      result = OUT_MAX;
    else if (shifted < (ACC_W+1)'(OUT_MIN)) result = OUT_MIN;
    else                                    result = shifted[OUT_W-1:0];
`else
    result = shifted[OUT_W-1:0];
`endif
  end

`ifndef FIR_SATURATE_EN
  // Upper bits are discarded by the wrap; tie them off explicitly.
  logic unused_hi;
  assign unused_hi = ^shifted[ACC_W:OUT_W];
`endif

  // Valid pipe tracks each sample from the delay line to the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpipe     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      vpipe     <= '0;
      out_valid <= 1'b0;
    end else begin
      vpipe     <= {vpipe[STAGES:0], in_valid};
      out_valid <= vpipe[STAGES+1];
      if (vpipe[STAGES+1]) out_data <= result;
    end
  end

endmodule

// File: tb/tb_fir_pipelined_tree.sv
// tb_fir_pipelined_tree
// Directed bench for fir_pipelined_tree. Instance A: TAPS=16, OUT_SHIFT=0
// (latency 6). Instance B: TAPS=5, OUT_SHIFT=1 (latency 5). Respects the
// FIR_SATURATE_EN build macro when forming saturation expectations.
module tb_fir_pipelined_tree;

  localparam int A_LAT = 6;
  localparam int B_LAT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic               a_clear, a_in_valid, a_coef_we, a_out_valid;
  logic signed [15:0] a_in_data, a_coef_wdata, a_out_data;
  logic [3:0]         a_coef_addr;

  logic               b_clear, b_in_valid, b_coef_we, b_out_valid;
  logic signed [15:0] b_in_data, b_coef_wdata, b_out_data;
  logic [2:0]         b_coef_addr;

  fir_pipelined_tree #(
    .DATA_W(16), .COEF_W(16), .TAPS(16), .OUT_W(16), .OUT_SHIFT(0)
  ) u_a (
    .clk(clk), .reset(reset), .clear(a_clear),
    .in_valid(a_in_valid), .in_data(a_in_data),
    .coef_we(a_coef_we), .coef_addr(a_coef_addr), .coef_wdata(a_coef_wdata),
    .out_valid(a_out_valid), .out_data(a_out_data)
  );

  fir_pipelined_tree #(
    .DATA_W(16), .COEF_W(16), .TAPS(5), .OUT_W(16), .OUT_SHIFT(1)
  ) u_b (
    .clk(clk), .reset(reset), .clear(b_clear),
    .in_valid(b_in_valid), .in_data(b_in_data),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_wdata(b_coef_wdata),
    .out_valid(b_out_valid), .out_data(b_out_data)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;

  logic signed [15:0] a_exp_q[$];
  int                 a_exp_t[$];
  logic signed [15:0] a_last = '0;
  logic signed [15:0] b_exp_q[$];
  int                 b_exp_t[$];
  logic signed [15:0] b_last = '0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Output checker: expected data at the expected edge, otherwise idle + hold.
  always @(posedge clk) begin
    #1;
    if (a_exp_t.size() != 0 && a_exp_t[0] == cyc) begin
      check("a_out_valid", a_out_valid, 1);
      check("a_out_data", a_out_data, a_exp_q[0]);
      a_last = a_exp_q[0];
      void'(a_exp_q.pop_front());
      void'(a_exp_t.pop_front());
    end else begin
      check("a_idle_valid", a_out_valid, 0);
      check("a_hold_data", a_out_data, a_last);
    end
    if (b_exp_t.size() != 0 && b_exp_t[0] == cyc) begin
      check("b_out_valid", b_out_valid, 1);
      check("b_out_data", b_out_data, b_exp_q[0]);
      b_last = b_exp_q[0];
      void'(b_exp_q.pop_front());
      void'(b_exp_t.pop_front());
    end else begin
      check("b_idle_valid", b_out_valid, 0);
      check("b_hold_data", b_out_data, b_last);
    end
  end

  // ---------------- driver tasks ----------------
  // One edge of stimulus on A (B held idle); records the expected output.
  task automatic a_cycle(input logic v, input logic signed [15:0] d, input logic clr,
                         input logic we, input logic [3:0] addr,
                         input logic signed [15:0] wd, input logic signed [15:0] exp);
    @(negedge clk);
    a_in_valid = v;  a_in_data = d;  a_clear = clr;
    a_coef_we = we;  a_coef_addr = addr;  a_coef_wdata = wd;
    b_in_valid = 1'b0;  b_clear = 1'b0;  b_coef_we = 1'b0;
    if (clr) begin
      a_exp_q.delete();
      a_exp_t.delete();
    end else if (v) begin
      a_exp_q.push_back(exp);
      a_exp_t.push_back(cyc + 1 + A_LAT);
    end
  endtask

  task automatic b_cycle(input logic v, input logic signed [15:0] d, input logic clr,
                         input logic we, input logic [2:0] addr,
                         input logic signed [15:0] wd, input logic signed [15:0] exp);
    @(negedge clk);
    b_in_valid = v;  b_in_data = d;  b_clear = clr;
    b_coef_we = we;  b_coef_addr = addr;  b_coef_wdata = wd;
    a_in_valid = 1'b0;  a_clear = 1'b0;  a_coef_we = 1'b0;
    if (clr) begin
      b_exp_q.delete();
      b_exp_t.delete();
    end else if (v) begin
      b_exp_q.push_back(exp);
      b_exp_t.push_back(cyc + 1 + B_LAT);
    end
  endtask

  task automatic a_idle();                                         a_cycle(0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic a_send(input logic signed [15:0] d, input logic signed [15:0] e); a_cycle(1, d, 0, 0, 0, 0, e); endtask
  task automatic a_write(input logic [3:0] ad, input logic signed [15:0] w);        a_cycle(0, 0, 0, 1, ad, w, 0); endtask
  task automatic a_clr();                                          a_cycle(0, 0, 1, 0, 0, 0, 0);  endtask
  task automatic b_send(input logic signed [15:0] d, input logic signed [15:0] e); b_cycle(1, d, 0, 0, 0, 0, e); endtask
  task automatic b_write(input logic [2:0] ad, input logic signed [15:0] w);        b_cycle(0, 0, 0, 1, ad, w, 0); endtask
  task automatic b_clr();                                          b_cycle(0, 0, 1, 0, 0, 0, 0);  endtask

  // Idle until every recorded expectation has had its edge (bounded).
  task automatic drain();
    int n = 0;
    while ((a_exp_q.size() + b_exp_q.size()) != 0 && n < 40) begin
      a_idle();
      n++;
    end
    repeat (2) a_idle();
  endtask

  function automatic int min16(input int n);
    return (n < 16) ? n : 16;
  endfunction

  // Reduce a full-precision sum to the 16-bit output of the current build.
  function automatic logic signed [15:0] lim16(input longint s);
`ifdef FIR_SATURATE_EN
    if (s > 32767)  return 16'sh7fff;
    if (s < -32768) return 16'sh8000;
    return 16'(s);
`else
    return 16'(s);
`endif
  endfunction

  // ---------------- stimulus ----------------
  longint p_pos, p_neg, s;
  int     m;

  initial begin
    reset = 1'b1;
    a_clear = 0; a_in_valid = 0; a_in_data = 0; a_coef_we = 0; a_coef_addr = 0; a_coef_wdata = 0;
    b_clear = 0; b_in_valid = 0; b_in_data = 0; b_coef_we = 0; b_coef_addr = 0; b_coef_wdata = 0;
    #1 reset = 1'b0;
    #2;
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_data", a_out_data, 0);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_b_data", b_out_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Impulse on A: coef[k]=k+1 -> 1..16 then zeros, 6-edge latency.
    for (int k = 0; k < 16; k++) a_write(4'(k), 16'(k + 1));
    a_send(1, 1);
    for (int n = 1; n < 20; n++) a_send(0, (n < 16) ? 16'(n + 1) : 16'sd0);
    drain();

    // Step of 3 with gaps, all coefs 1: ramp 3..48, then holds 48.
    for (int k = 0; k < 16; k++) a_write(4'(k), 1);
    for (int n = 0; n < 18; n++) begin
      a_send(3, 16'(3 * min16(n + 1)));
      a_idle();
    end
    drain();

    // Saturation: full-scale positive then full-scale negative stream.
    for (int k = 0; k < 16; k++) a_write(4'(k), 32767);
    a_clr();
    p_pos = 64'sd32767 * 64'sd32767;
    p_neg = -64'sd32767 * 64'sd32768;
    for (int n = 0; n < 20; n++) a_send(32767, lim16(p_pos * min16(n + 1)));
    for (int n = 0; n < 20; n++) begin
      m = min16(n + 1);
      s = p_pos * (16 - m) + p_neg * m;
      a_send(-32768, lim16(s));
    end
    drain();

    // Mid-stream write of coef[0]=5 on the same edge as sample 10.
    for (int k = 0; k < 16; k++) a_write(4'(k), 1);
    a_clr();
    for (int n = 0; n < 24; n++) begin
      if (n == 10) a_cycle(1, 1, 0, 1, 0, 5, 16'(min16(n + 1) + 4));
      else         a_send(1, 16'(min16(n + 1) + ((n >= 10) ? 4 : 0)));
    end
    // Clear with in_valid high drops the sample and everything in flight.
    a_cycle(1, 7, 1, 0, 0, 0, 0);
    for (int n = 0; n < 6; n++) a_send(1, 16'(5 + n));
    drain();

    // B rounding: coef0=1, OUT_SHIFT=1.
    b_write(0, 1);
    for (int k = 1; k < 5; k++) b_write(3'(k), 0);
    b_send(3, 2);
    b_send(-3, -1);
    b_send(1, 1);
    b_send(-1, 0);
    b_send(-2, -1);
    drain();

    // B impulse with coefs 10,8,6,4,2 (halved by rounding shift); writes
    // to addresses 5..7 lie beyond TAPS and must not alter any tap.
    b_clr();
    for (int k = 0; k < 5; k++) b_write(3'(k), 16'(10 - 2 * k));
    for (int k = 5; k < 8; k++) b_write(3'(k), 99);
    b_send(1, 5);
    for (int n = 1; n < 8; n++) b_send(0, (n < 5) ? 16'(5 - n) : 16'sd0);
    drain();

    // Async reset mid-stream on A (coef0=5, others 1; 6 ones in the line).
    for (int n = 0; n < 10; n++) a_send(1, 16'(5 + min16(7 + n) - 1));
    #2;
    check("pre_rst_valid", a_out_valid, 1);
    a_exp_q.delete();  a_exp_t.delete();
    b_exp_q.delete();  b_exp_t.delete();
    a_last = '0;  b_last = '0;
    a_in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("async_rst_valid", a_out_valid, 0);
    check("async_rst_data", a_out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    // Coefficients are gone after reset: ones in -> zeros out.
    for (int n = 0; n < 8; n++) a_send(1, 0);
    a_write(0, 7);
    a_send(1, 7);
    a_send(1, 7);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
